// File: rtl/fft_bitrev_unload_pkg.sv
// ---------------------------------------------------------------------------
// fft_bitrev_unload_pkg
// Shared definitions for the FFT bit-reversed unload stage:
//   - default frame size / sample width constants
//   - bitrev() helper used to turn a linear sample count into a RAM address
//   - writer / reader FSM state encodings
//   - debug snapshot struct exported by the top level
// ---------------------------------------------------------------------------
package fft_bitrev_unload_pkg;

    localparam int FFT_LOG2N     = 10;
    localparam int FFT_WIDTH     = 8;
    // Widest index bitrev() accepts; LOG2N of any instance must not exceed it.
    localparam int FFT_MAX_LOG2N = 16;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Snapshot of both FSMs and the bank bookkeeping, for checkers and probes.
    typedef struct packed {
        wr_state_e  wr_state;
        rd_state_e  rd_state;
        logic       wr_bank;
        logic       rd_bank;
        logic [1:0] bank_full;
        logic       overflow;
    } unload_dbg_t;

    // Reverse the low log2n bits of idx. The full-width word is mirrored and
    // then shifted down so the reversed field lands in bits [log2n-1:0].
    function automatic logic [FFT_MAX_LOG2N-1:0] bitrev(
        input logic [FFT_MAX_LOG2N-1:0] idx,
        input int                       log2n
    );
        logic [FFT_MAX_LOG2N-1:0] mirrored;
        mirrored = {<<{idx}};
        return mirrored >> (FFT_MAX_LOG2N - log2n);
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// ---------------------------------------------------------------------------
// fft_pingpong_ram
// Simple dual-port RAM holding both ping-pong banks (bank = address MSB).
// One write port, one registered read port, both qualified by a shared
// clock enable so the whole array freezes when en_i is low.
// Ports:
//   clock_c  : clock
//   en_i     : shared clock enable
//   we_i     : write request (acted on only when en_i=1)
//   waddr_i  : write address {bank, offset}
//   wdata_i  : write data
//   re_i     : read request (acted on only when en_i=1)
//   raddr_i  : read address {bank, offset}
//   rdata_o  : read data, valid one enabled cycle after the request
// ---------------------------------------------------------------------------
module fft_pingpong_ram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clock_c,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // No reset on the array or the read register so this maps onto block RAM.
    always_ff @(posedge clock_c) begin
        if (en_i && we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (en_i && re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_unload.sv
// ---------------------------------------------------------------------------
// fft_bitrev_unload
// Reorders FFT frames from bit-reversed to natural bin order. Each incoming
// frame is written into one half of a ping-pong RAM at bitrev(sample index);
// the other half is replayed linearly (0..N-1) with its own sync/valid.
//
// Output handshake: valid_o qualifies data_0_o/data_1_o on every enabled
// cycle; there is no backpressure, the consumer must take every enabled
// valid beat. sync_o marks natural bin 0 and is only ever high with valid_o.
//
// Ports:
//   clock_c    : clock, rising edge
//   reset_i    : synchronous active-high reset
//   enable_i   : global clock enable shared with the FFT core
//   sync_i     : first sample (bit-reversed index 0) of an FFT frame
//   data_0_i   : real part in, data_1_i : imag part in
//   sync_o     : natural bin 0 marker
//   valid_o    : replayed bin present on data outputs
//   data_0_o   : real part out, data_1_o : imag part out
//   overflow_o : sticky, a completed frame was dropped (reset clears)
//   dbg_o      : FSM state / bank bookkeeping snapshot
// ---------------------------------------------------------------------------
module fft_bitrev_unload
    import fft_bitrev_unload_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N,
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic             clock_c,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             sync_i,
    input  logic [WIDTH-1:0] data_0_i,
    input  logic [WIDTH-1:0] data_1_i,
    output logic             sync_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_0_o,
    output logic [WIDTH-1:0] data_1_o,
    output logic             overflow_o,
    output unload_dbg_t      dbg_o
);

    localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

    // Writer state
    wr_state_e        wr_state_q, wr_state_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             overflow_q, overflow_d;

    // Bank bookkeeping: bit b set means bank b holds a complete frame
    logic [1:0]       full_q, full_d;
    logic [1:0]       set_full, clr_full;

    // Reader state
    rd_state_e        rd_state_q, rd_state_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic [LOG2N-1:0] rd_next;
    logic             rd_bank_q, rd_bank_d;
    // rd_issue/rd_first track the RAM read register: they say whether it
    // holds a bin of the current frame and whether that bin is bin 0.
    logic             rd_issue_q, rd_issue_d;
    logic             rd_first_q, rd_first_d;

    // Output registers
    logic             sync_q, sync_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_0_q, data_0_d;
    logic [WIDTH-1:0] data_1_q, data_1_d;

    // RAM interface
    logic             ram_we;
    logic [LOG2N-1:0] ram_waddr_lo;
    logic [LOG2N-1:0] wr_addr_rev;
    logic             rd_req;
    logic [LOG2N-1:0] ram_raddr_lo;
    logic [2*WIDTH-1:0] ram_rdata;

    // Advance qualifier for the read side and output pipeline. Kept as a
    // distinct net so the read path can be stalled independently of the
    // writer when probing the drop behaviour.
    logic             rd_step;
    assign rd_step = enable_i;

    assign wr_addr_rev = LOG2N'(bitrev(FFT_MAX_LOG2N'(wr_cnt_q), LOG2N));
    assign rd_next     = rd_cnt_q + LOG2N'(1);

    // ---------------- writer FSM ----------------
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_cnt_d     = wr_cnt_q;
        wr_bank_d    = wr_bank_q;
        overflow_d   = overflow_q;
        set_full     = 2'b00;
        ram_we       = 1'b0;
        ram_waddr_lo = '0;
        if (enable_i) begin
            unique case (wr_state_q)
                WR_IDLE: begin
                    if (sync_i) begin
                        if (full_q[wr_bank_q]) begin
                            // Target bank not yet drained: drop the frame.
                            // Staying in IDLE ignores its remaining samples.
                            overflow_d = 1'b1;
                        end else begin
                            ram_we     = 1'b1;
                            wr_cnt_d   = LOG2N'(1);
                            wr_state_d = WR_FILL;
                        end
                    end
                end
                WR_FILL: begin
                    ram_we = 1'b1;
                    if (sync_i) begin
                        // Restart in the same bank; this sample is bin 0.
                        wr_cnt_d = LOG2N'(1);
                    end else begin
                        ram_waddr_lo = wr_addr_rev;
                        wr_cnt_d     = wr_cnt_q + LOG2N'(1);
                        if (wr_cnt_q == LAST) begin
                            set_full[wr_bank_q] = 1'b1;
                            wr_bank_d           = ~wr_bank_q;
                            wr_state_d          = WR_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- reader FSM ----------------
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_cnt_d     = rd_cnt_q;
        rd_bank_d    = rd_bank_q;
        clr_full     = 2'b00;
        rd_req       = 1'b0;
        ram_raddr_lo = '0;
        rd_issue_d   = rd_issue_q;
        rd_first_d   = rd_first_q;
        if (rd_step) begin
            rd_issue_d = 1'b0;
            rd_first_d = 1'b0;
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        rd_req     = 1'b1;
                        rd_issue_d = 1'b1;
                        rd_first_d = 1'b1;
                        rd_cnt_d   = '0;
                        rd_state_d = RD_READ;
                    end
                end
                RD_READ: begin
                    rd_req       = 1'b1;
                    rd_issue_d   = 1'b1;
                    ram_raddr_lo = rd_next;
                    rd_cnt_d     = rd_next;
                    if (rd_next == LAST) begin
                        // Last address issued: bank can be refilled, and the
                        // other bank may start replay on the next cycle.
                        clr_full[rd_bank_q] = 1'b1;
                        rd_bank_d           = ~rd_bank_q;
                        rd_state_d          = RD_IDLE;
                    end
                end
            endcase
        end
    end

    // Writer only sets the bank it fills and reader only clears the bank it
    // drains; the two are never the same bank.
    assign full_d = (full_q | set_full) & ~clr_full;

    // ---------------- output pipeline ----------------
    always_comb begin
        sync_d   = sync_q;
        valid_d  = valid_q;
        data_0_d = data_0_q;
        data_1_d = data_1_q;
        if (rd_step) begin
            sync_d  = rd_first_q;
            valid_d = rd_issue_q;
            if (rd_issue_q) begin
                data_0_d = ram_rdata[WIDTH-1:0];
                data_1_d = ram_rdata[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clock_c) begin
        if (reset_i) begin
            wr_state_q <= WR_IDLE;
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            overflow_q <= 1'b0;
            full_q     <= 2'b00;
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_issue_q <= 1'b0;
            rd_first_q <= 1'b0;
            sync_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_0_q   <= '0;
            data_1_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_bank_q  <= rd_bank_d;
            rd_issue_q <= rd_issue_d;
            rd_first_q <= rd_first_d;
            sync_q     <= sync_d;
            valid_q    <= valid_d;
            data_0_q   <= data_0_d;
            data_1_q   <= data_1_d;
        end
    end

    fft_pingpong_ram #(
        .AW (LOG2N + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .clock_c (clock_c),
        .en_i    (enable_i),
        .we_i    (ram_we),
        .waddr_i ({wr_bank_q, ram_waddr_lo}),
        .wdata_i ({data_1_i, data_0_i}),
        .re_i    (rd_req),
        .raddr_i ({rd_bank_q, ram_raddr_lo}),
        .rdata_o (ram_rdata)
    );

    assign sync_o     = sync_q;
    assign valid_o    = valid_q;
    assign data_0_o   = data_0_q;
    assign data_1_o   = data_1_q;
    assign overflow_o = overflow_q;

    always_comb begin
        dbg_o           = '0;
        dbg_o.wr_state  = wr_state_q;
        dbg_o.rd_state  = rd_state_q;
        dbg_o.wr_bank   = wr_bank_q;
        dbg_o.rd_bank   = rd_bank_q;
        dbg_o.bank_full = full_q;
        dbg_o.overflow  = overflow_q;
    end

endmodule
